// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor_if
//  Description : Signal bundle between the PLL lock supervisor and its
//                surroundings (PLL lock input, relock request, the reset
//                outputs and status counters).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lol_count;

    // Supervisor side: consumes lock/relock, drives resets and status.
    modport master (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retry_count,
        output lol_count
    );

    // PLL / datapath side.
    modport slave (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retry_count,
        input  lol_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Sequences the reference-clocked PLL: holds it in reset,
//                waits for a synchronized lock with timeout and bounded
//                retries, requires lock stability before releasing the
//                datapath reset, and restarts on loss of lock or request.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.master sup
);

    localparam int c_hold_w    = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int c_stable_w  = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int c_timeout_w = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

    // Last count value of each phase: the transition fires on that cycle,
    // so each phase occupies exactly its parameter's number of cycles.
    localparam logic [c_hold_w-1:0]    c_hold_last    = c_hold_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_stable_w-1:0]  c_stable_last  = c_stable_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_timeout_w-1:0] c_timeout_last = c_timeout_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]             c_max_retries  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [c_hold_w-1:0]    hold_cnt_q, hold_cnt_d;
    logic [c_stable_w-1:0]  stable_cnt_q, stable_cnt_d;
    logic [c_timeout_w-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [3:0]             retry_count_q, retry_count_d;
    logic [7:0]             lol_count_q, lol_count_d;
    logic                   sync_meta_q, sync_meta_d;
    logic                   lock_s_q, lock_s_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    // Two-stage synchronizer feed for the asynchronous PLL lock indication.
    always_comb begin
        sync_meta_d = sup.pll_locked;
        lock_s_d    = sync_meta_q;
    end

    // Synchronizer flops, cleared by reset so a stale lock is never seen.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            lock_s_q    <= lock_s_d;
        end
    end

    // Next-state, counter and registered-output logic of the sequencer.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        retry_count_d = retry_count_q;
        lol_count_d   = lol_count_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (hold_cnt_q == c_hold_last) begin
                    state_d       = ST_WAIT_LOCK;
                    timeout_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + c_hold_w'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d      = ST_STABILIZE;
                    stable_cnt_d = '0;
                end else if (timeout_cnt_q == c_timeout_last) begin
                    retry_count_d = retry_count_q + 4'd1;
                    hold_cnt_d    = '0;
                    state_d       = (retry_count_d == c_max_retries) ? ST_FAULT : ST_RESET_PLL;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + c_timeout_w'(1);
                end
            end
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    // A glitch restarts the lock wait without costing a retry.
                    state_d       = ST_WAIT_LOCK;
                    timeout_cnt_d = '0;
                end else if (stable_cnt_q == c_stable_last) begin
                    state_d       = ST_RUN;
                    retry_count_d = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + c_stable_w'(1);
                end
            end
            ST_RUN: begin
                // Loss of lock is counted even when a relock request coincides.
                if (!lock_s_q) begin
                    state_d    = ST_RESET_PLL;
                    hold_cnt_d = '0;
                    if (lol_count_q != 8'hFF) begin
                        lol_count_d = lol_count_q + 8'd1;
                    end
                end else if (sup.force_relock) begin
                    state_d    = ST_RESET_PLL;
                    hold_cnt_d = '0;
                end
            end
            ST_FAULT: begin
                if (sup.force_relock) begin
                    state_d       = ST_RESET_PLL;
                    hold_cnt_d    = '0;
                    retry_count_d = '0;
                end
            end
            default: begin
                state_d    = ST_RESET_PLL;
                hold_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    // State, counters and outputs; reset dominates every other input.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= ST_RESET_PLL;
            hold_cnt_q    <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            retry_count_q <= '0;
            lol_count_q   <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            retry_count_q <= retry_count_d;
            lol_count_q   <= lol_count_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign sup.pll_rst     = pll_rst_q;
    assign sup.sys_rst     = sys_rst_q;
    assign sup.ready       = ready_q;
    assign sup.fault       = fault_q;
    assign sup.retry_count = retry_count_q;
    assign sup.lol_count   = lol_count_q;

endmodule
`default_nettype wire
